ibex_mdu_iter: RTL and testbench
================================

// Module: ibex_mdu_iter
// PURPOSE
// Parametrised iterative multiply/divide unit for the EX stage: RV32M ops at any data width.
// Multiply throughput is configurable in bits per cycle. Optional early termination.
// Decoupled valid/ready handshake on both sides replaces the multdiv_en/ready_id coupling.
// Private adder: no ALU adder sharing and no imd_val register use.
// PARAMETERS
// Width          32  operand/result width; even, >= 8
// MulBitsPerCyc  1   multiplier bits retired per MUL iteration; 1, 2 or 4; must divide Width
// EarlyTerm      1   1: MUL ends once remaining multiplier magnitude bits are all zero
// PORTS
// clk_i            in   1      clock
// rst_ni           in   1      synchronous active-low reset
// in_valid_i       in   1      operation request
// in_ready_o       out  1      unit can accept (high only in IDLE)
// op_i             in   3      0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
// op_a_i           in   Width  rs1 operand
// op_b_i           in   Width  rs2 operand
// data_ind_timing_i in  1      1: disable early termination (fixed latency)
// kill_i           in   1      flush: abandon current op
// out_valid_o      out  1      result valid
// out_ready_i      in   1      consumer accepts result
// result_o         out  Width  result
// busy_o           out  1      state != IDLE
// BEHAVIOUR
// - Reset (rst_ni low at clk edge): state IDLE, in_ready_o=1, out_valid_o=0, result_o=0, busy_o=0.
// - States: IDLE -> MUL|DIV -> FIX -> DONE -> IDLE. in_ready_o = (state==IDLE).
// - Accept at edge t0 when in_valid_i & in_ready_o & !kill_i.
//   At accept: latch op, operand signs and magnitudes, and clear the counter.
//   Operand signedness: a signed for MULH/MULHSU/DIV/REM; b signed for MULH/DIV/REM.
// - DIVU/DIV/REM/REMU with op_b_i==0: fast path from IDLE straight to DONE.
//   out_valid_o high after t0+1. Quotient = all ones; remainder = op_a_i unchanged.
// - MUL state: shift-add on magnitudes, MulBitsPerCyc bits per cycle.
//   N = Width/MulBitsPerCyc iterations. Full 2*Width product accumulator.
// - DIV state: restoring division on magnitudes, Width iterations, 1 quotient bit per cycle.
// - Early exit (MUL only): when EarlyTerm=1 and data_ind_timing_i=0, leave MUL once the
//   unconsumed multiplier bits are all zero. The product is then shifted into final position in FIX.
//   DIV latency is always fixed.
// - FIX (1 cycle): apply sign correction, then select the low or high half (or Q or R).
//   Product negated iff sign_a^sign_b. Quotient negated iff sign_a^sign_b.
//   Remainder takes sign_a. Both are two's complement, truncated to Width.
//   Signed overflow (MIN / -1) needs no special path: Q=MIN, R=0.
// - Latency without early exit: out_valid_o first high N+2 edges after t0 (MUL).
//   DIV: Width+2 edges after t0.
// - DONE: out_valid_o=1; result_o and out_valid_o held stable while out_ready_i=0.
//   On out_valid_o & out_ready_i: IDLE next edge. No accept in the same cycle.
// - kill_i in any state: IDLE next edge, out_valid_o=0, and the result is never presented.
//   kill_i has priority over accept and over the output handshake.
// - result_o keeps its last value outside DONE; only out_valid_o qualifies it.
// - in_valid_i while busy is ignored. Inputs are sampled only at accept.
// - No combinational path from in_valid_i/out_ready_i to in_ready_o/out_valid_o.
// TESTING
// Width=32, MulBitsPerCyc=1 unless noted.
// 1 MULH a=0x80000000 b=0x80000000, data_ind=1 -> result 0x40000000; out_valid at t0+34.
// 2 DIV a=0xFFFFFFF9 b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; both at t0+34.
// 3 DIVU a=5 b=0 -> 0xFFFFFFFF at t0+1; REM a=5 b=0 -> 5; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000.
// 4 MUL a=3 b=1 data_ind=0 -> 3 before t0+34; same op with data_ind=1 -> exactly t0+34.
// 5 out_ready low 5 cycles in DONE -> result/out_valid stable, in_ready 0; then handshake -> in_ready 1 next cycle.
// 6 kill_i at iteration 10, and kill_i with in_valid in IDLE -> no out_valid, no accept; reset mid-DIV -> IDLE outputs.

Source files
------------

// File: rtl/ibex_mdu_iter.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes on both sides.
// Shift-add multiply (optional early exit), restoring divide, one-cycle sign fix-up.
module ibex_mdu_iter #(
    parameter int unsigned Width         = 32,
    parameter int unsigned MulBitsPerCyc = 1,
    parameter bit          EarlyTerm     = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [Width-1:0] op_a_i,
    input  logic [Width-1:0] op_b_i,
    input  logic             data_ind_timing_i,
    input  logic             kill_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] result_o,
    output logic             busy_o
);

    localparam int unsigned NIter = Width / MulBitsPerCyc;
    localparam int unsigned CntW  = $clog2(Width + 1);
    localparam int unsigned K     = MulBitsPerCyc;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_e;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    state_e             state;
    op_e                op_q;
    logic               sign_a, sign_b, early_en;
    logic [Width-1:0]   mag_a, mag_b;
    logic [2*Width-1:0] acc;
    logic [CntW-1:0]    cnt;
    logic [Width-1:0]   result_q;
    logic               out_valid_q;

    // Operand decode at accept time
    op_e              op_in;
    logic             in_sign_a, in_sign_b, accept;
    logic [Width-1:0] in_mag_a, in_mag_b;

    always_comb begin
        op_in     = op_e'(op_i);
        in_sign_a = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & op_a_i[Width-1];
        in_sign_b = (op_in inside {OP_MULH, OP_DIV, OP_REM}) & op_b_i[Width-1];
        in_mag_a  = in_sign_a ? -op_a_i : op_a_i;
        in_mag_b  = in_sign_b ? -op_b_i : op_b_i;
        accept    = in_valid_i & (state == IDLE) & ~kill_i;
    end

    // Multiply step: mag_b doubles as the multiplier shift register.
    logic [K-1:0]       digit;
    logic [Width+K-1:0] mul_sum;
    logic [2*Width-1:0] mul_acc;
    logic [Width-1:0]   mplier_next;

    always_comb begin
        digit       = mag_b[K-1:0];
        mul_sum     = (Width+K)'(acc[2*Width-1:Width]) + (Width+K)'(mag_a) * (Width+K)'(digit);
        mul_acc     = {mul_sum, acc[Width-1:K]};
        mplier_next = mag_b >> K;
    end

    // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
    logic [Width:0]     div_diff;
    logic [2*Width-1:0] div_acc;

    always_comb begin
        div_diff = acc[2*Width-1:Width-1] - {1'b0, mag_b};
        div_acc  = div_diff[Width] ? {acc[2*Width-2:0], 1'b0}
                                   : {div_diff[Width-1:0], acc[Width-2:0], 1'b1};
    end

    // Fix-up: an early-exited product still needs its remaining right shifts.
    logic [CntW-1:0]    mul_sh;
    logic [2*Width-1:0] prod_mag, prod;
    logic [Width-1:0]   quo, rem, fix_result;

    always_comb begin
        mul_sh   = (CntW'(NIter) - cnt) * CntW'(K);
        prod_mag = acc >> mul_sh;
        prod     = (sign_a ^ sign_b) ? -prod_mag : prod_mag;
        quo      = (sign_a ^ sign_b) ? -acc[Width-1:0] : acc[Width-1:0];
        rem      = sign_a ? -acc[2*Width-1:Width] : acc[2*Width-1:Width];
        case (op_q)
            OP_MUL:                 fix_result = prod[Width-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:               fix_result = prod[2*Width-1:Width];
            OP_DIV, OP_DIVU:        fix_result = quo;
            default:                fix_result = rem;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            op_q        <= OP_MUL;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            early_en    <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            acc         <= '0;
            cnt         <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (kill_i) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q     <= op_in;
                    sign_a   <= in_sign_a;
                    sign_b   <= in_sign_b;
                    early_en <= EarlyTerm & ~data_ind_timing_i;
                    mag_a    <= in_mag_a;
                    mag_b    <= in_mag_b;
                    cnt      <= '0;
                    if (op_i[2] && op_b_i == '0) begin
                        result_q <= op_i[1] ? op_a_i : '1;
                        state    <= DONE;
                    end else if (op_i[2]) begin
                        acc   <= {{Width{1'b0}}, in_mag_a};
                        state <= DIV;
                    end else begin
                        acc   <= '0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc   <= mul_acc;
                    mag_b <= mplier_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CntW'(NIter - 1) || (early_en && mplier_next == '0))
                        state <= FIX;
                end
                DIV: begin
                    acc <= div_acc;
                    cnt <= cnt + 1'b1;
                    if (cnt == CntW'(Width - 1)) state <= FIX;
                end
                FIX: begin
                    result_q <= fix_result;
                    state    <= DONE;
                end
                DONE: begin
                    if (out_valid_q && out_ready_i) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_ibex_mdu_iter.sv
// Directed bench for ibex_mdu_iter: vector table plus stall, kill and reset sequences.
module tb_ibex_mdu_iter;

    logic        clk, rst_n;
    logic        in_valid, in_ready, di, kill, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] a, b, result;

    ibex_mdu_iter #(.Width(32), .MulBitsPerCyc(1), .EarlyTerm(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .op_a_i(a), .op_b_i(b), .data_ind_timing_i(di), .kill_i(kill),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        di;
        logic [31:0] exp;
        int          lat;   // -1: early exit, must be below 34
    } vec_t;

    vec_t vecs[20];
    int   n_vec = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic d);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; di = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        int k;
        lat = 0;
        k   = 0;
        while (lat == 0 && k < 100) begin
            @(posedge clk);
            #1 k++;
            if (out_valid) lat = k;
        end
        if (lat == 0) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake();
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic saw;
        //        op    a             b             di    exp           lat
        vecs[0]  = '{3'd1, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 34};
        vecs[1]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFD, 34};
        vecs[2]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFF, 34};
        vecs[3]  = '{3'd5, 32'h00000005, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1};
        vecs[4]  = '{3'd6, 32'h00000005, 32'h00000000, 1'b0, 32'h00000005, 1};
        vecs[5]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 34};
        vecs[6]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 34};
        vecs[7]  = '{3'd0, 32'h00000003, 32'h00000001, 1'b0, 32'h00000003, -1};
        vecs[8]  = '{3'd0, 32'h00000003, 32'h00000001, 1'b1, 32'h00000003, 34};
        vecs[9]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 34};
        vecs[10] = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 1'b1, 32'hFFFFFFFF, 34};
        vecs[11] = '{3'd0, 32'h12345678, 32'h00000010, 1'b0, 32'h23456780, -1};
        vecs[12] = '{3'd5, 32'd100,      32'd7,        1'b0, 32'd14,       34};
        vecs[13] = '{3'd7, 32'd100,      32'd7,        1'b0, 32'd2,        34};
        vecs[14] = '{3'd1, 32'hFFFFFFFD, 32'h00000005, 1'b0, 32'hFFFFFFFF, -1};
        vecs[15] = '{3'd4, 32'h00000007, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFD, 34};
        vecs[16] = '{3'd6, 32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h00000001, 34};
        vecs[17] = '{3'd4, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1};
        vecs[18] = '{3'd7, 32'h00001234, 32'h00000000, 1'b0, 32'h00001234, 1};
        vecs[19] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 34};

        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; di = 1'b0;
        kill = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].di);
            wait_valid(lat);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp);
            if (vecs[i].lat < 0) check($sformatf("vec%0d_early", i), {31'd0, lat < 34}, 32'd1);
            else                 check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            handshake();
        end

        // Output stall, with a stray request while busy that must be ignored
        start(3'd5, 32'd100, 32'd7, 1'b0);
        @(negedge clk) in_valid = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        wait_valid(lat);
        in_valid = 1'b0;
        check("stall_latency", lat, 34);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_result", result, 32'd14);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        handshake();
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);

        // Kill during the tenth divide iteration
        start(3'd4, 32'd1000, 32'd3, 1'b0);
        out_ready = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk) kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check("kill_busy", {31'd0, busy}, 32'd0);
        check("kill_in_ready", {31'd0, in_ready}, 32'd1);
        saw = 1'b0;
        repeat (40) begin @(posedge clk); #1 saw |= out_valid; end
        check("kill_no_valid", {31'd0, saw}, 32'd0);

        // Kill together with a request in IDLE: nothing accepted
        @(negedge clk) in_valid = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3; di = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; kill = 1'b0;
        check("kill_idle_busy", {31'd0, busy}, 32'd0);
        saw = 1'b0;
        repeat (40) begin @(posedge clk); #1 saw |= out_valid; end
        check("kill_idle_no_valid", {31'd0, saw}, 32'd0);
        out_ready = 1'b0;

        // Reset in the middle of a divide (result currently holds 14)
        start(3'd5, 32'd50, 32'd5, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
